posit16_pack: RTL and testbench
===============================

Name: posit16_pack

Overview:
- Downstream neighbour of the 16-bit regime generator in the float-to-posit conversion path.
- Takes the regime bitstring produced by the generator, together with the sign, scale and float fraction of the same operand.
- Assembles a posit<16,0> word: fraction placement, round-to-nearest-even and two's-complement negation.
- Two-stage pipeline with valid/ready handshake; sits between the float unpacker/regime generator and the posit result register.

Parameters:
- FRAC_W, 23, width of incoming float fraction (hidden bit excluded); must be >= 15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block accepts operand this cycle
- in_sign  in  1  operand sign
- in_zero  in  1  operand is zero
- in_nar  in  1  operand is NaN/Inf (maps to NaR)
- in_exp  in  16  signed scale k (es=0, so scale = regime value)
- in_frac  in  FRAC_W  float fraction, MSB = 2^-1
- in_regbits  in  16  regime bitstring from the regime generator for in_exp: bit15=0, regime left-aligned at bit14
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_posit  out  16  posit<16,0> result
- out_inexact  out  1  nonzero bits were discarded (rounded)

Behaviour:
- Interface: one clock (clk); reset synchronous and active-high (rst).
- Reset: out_valid=0, out_posit=0x0000, out_inexact=0, both stage valids cleared. in_ready=1 in the first cycle after reset.
  - rst mid-operation drops all in-flight operands with no output.
- Handshake:
  - Transfer occurs when valid && ready.
  - out_posit and out_inexact hold stable while out_valid && !out_ready.
  - Stage enable: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en.
  - Full throughput: 1 operand per cycle. Latency: 2 cycles from input transfer to out_valid.
  - Simultaneous output pop and input push when full is legal and loses nothing.
- Stage 1 (capture/align):
  - reglen = k>=0 ? k+2 : 1-k.
  - fbits = 15 - reglen, floored at 0.
  - Body = in_regbits[14:0] OR (in_frac top fbits bits placed directly below the regime terminator).
  - Guard = next fraction bit; sticky = OR of all remaining fraction bits.
  - Register body, guard, sticky, sign, and the special class (zero/nar/sat_hi/sat_lo/normal).
- Special cases, priority in order:
  - in_nar → 0x8000.
  - in_zero → 0x0000.
  - k >= 14 → body 0x7FFF (maxpos), inexact = (k>14) || frac!=0.
  - k <= -14 → body 0x0001 (minpos; never rounds to zero), inexact = (k<-14) || frac!=0.
- Stage 2 (round/negate):
  - RNE: increment = guard && (sticky || body[0]).
  - Body is 15-bit unsigned. Carry may propagate into the regime (monotone encoding). The result cannot exceed 0x7FFF for k<=13.
  - inexact = guard || sticky.
  - Negative operand: out_posit = (~{1'b0,body}) + 1. NaR and zero are not negated.
- Width rules:
  - in_exp is interpreted signed.
  - Only in_regbits[14:0] is used; bit15 is ignored.
  - in_regbits must correspond to in_exp in the same cycle. No consistency check is made.

Optional Feature:
- Macro POSIT16_PACK_RNE_EN.
- Defined: round-to-nearest-even as described.
- Undefined: truncation. Increment is forced 0, out_inexact is still reported, and the guard/sticky logic is retained only for inexact.

Test Plan:
- k=0, frac=0, regbits=0x4000 → 0x4000 after 2 cycles; k=1 (regbits 0x6000) → 0x6000; k=-1 (regbits 0x2000) → 0x2000; inexact=0 for all.
- k=0, frac=0x400000 → 0x5000; same with sign=1 → 0xB000; k=0, sign=1, frac=0 → 0xC000.
- RNE, k=0:
  - frac=0x000200 (tie, lsb 0) → 0x4000, inexact=1.
  - frac=0x000600 (tie, lsb 1) → 0x4002, inexact=1.
  - frac=0x000201 → 0x4001.
  - Without the macro, frac=0x000600 → 0x4001.
- Saturation:
  - k=20 → 0x7FFF, inexact=1.
  - k=-20, sign=1 → 0xFFFF.
  - k=13, frac=0x7FFFFF → 0x7FFF.
  - in_nar=1 → 0x8000; in_zero=1 → 0x0000.
- Backpressure:
  - Stream 8 back-to-back operands with out_ready toggling 1-0-0-1…
  - Every result appears exactly once, in order, and holds stable while stalled.
  - in_ready drops only when both stages are full and out_ready=0.
- Reset: assert rst for 1 cycle while 2 operands are in flight → out_valid=0 next cycle, no stale results afterwards, in_ready=1.

Source files
------------

// File: rtl/posit16_pack.sv
// posit16_pack: assembles a posit<16,0> word from a regime bitstring, sign,
// scale and float fraction. Two-stage valid/ready pipeline:
// stage 1 aligns the fraction under the regime, stage 2 rounds and negates.
// Optional macro POSIT16_PACK_RNE_EN: when defined, round-to-nearest-even;
// when undefined, results are truncated (out_inexact still reported).
module posit16_pack #(
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic              in_zero,
    input  logic              in_nar,
    input  logic [15:0]       in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [15:0]       in_regbits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_posit,
    output logic              out_inexact
);

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_NAR,
        CLS_SAT_HI,
        CLS_SAT_LO
    } cls_t;

    // pipeline control
    logic w_s1_en;
    logic w_s2_en;

    // stage 1 registers
    logic        r_s1_valid;
    logic [14:0] r_s1_body;
    logic        r_s1_guard;
    logic        r_s1_sticky;
    logic        r_s1_sign;
    cls_t        r_s1_cls;

    // stage 2 (output) registers
    logic        r_s2_valid;
    logic [15:0] r_posit;
    logic        r_inexact;

    // stage 1 combinational
    logic signed [17:0]      w_k;
    logic signed [17:0]      w_reglen;
    logic [3:0]              w_fbits;
    logic [FRAC_W+14:0]      w_fx;
    logic [14:0]             w_body;
    logic                    w_guard;
    logic                    w_sticky;
    cls_t                    w_cls;

    // stage 2 combinational
    logic        w_inc;
    logic [15:0] w_mag;
    logic [15:0] w_res_posit;
    logic        w_res_inexact;

    // regime MSB (bit15) is always zero by construction and is not needed
    logic w_unused_ok;
    assign w_unused_ok = in_regbits[15];

    assign w_s2_en   = !r_s2_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_s2_valid;
    assign out_posit = r_posit;
    assign out_inexact = r_inexact;

    // Stage 1: place fraction bits directly below the regime terminator and
    // split the discarded bits into guard and sticky; classify specials.
    always_comb begin
        w_k      = {{2{in_exp[15]}}, in_exp};
        w_reglen = w_k[17] ? (18'sd1 - w_k) : (w_k + 18'sd2);
        w_fbits  = (w_reglen >= 18'sd15) ? 4'd0 : 4'(18'sd15 - w_reglen);
        // fraction shifted left by fbits: its top fbits bits land in the
        // 15-bit body field, the next bit is guard, the rest feed sticky
        w_fx     = {15'b0, in_frac} << w_fbits;
        w_body   = in_regbits[14:0] | w_fx[FRAC_W+14:FRAC_W];
        w_guard  = w_fx[FRAC_W-1];
        w_sticky = |w_fx[FRAC_W-2:0];
        w_cls    = CLS_NORMAL;
        if (in_nar) begin
            w_cls = CLS_NAR;
        end else if (in_zero) begin
            w_cls = CLS_ZERO;
        end else if (w_k >= 18'sd14) begin
            w_cls    = CLS_SAT_HI;
            w_body   = 15'h7FFF;
            w_guard  = 1'b0;
            w_sticky = (w_k > 18'sd14) || (|in_frac);
        end else if (w_k <= -18'sd14) begin
            w_cls    = CLS_SAT_LO;
            w_body   = 15'h0001;
            w_guard  = 1'b0;
            w_sticky = (w_k < -18'sd14) || (|in_frac);
        end
    end

    // Stage 1 register: capture aligned body, rounding bits and class
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_body   <= '0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_cls    <= CLS_NORMAL;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_body   <= w_body;
                r_s1_guard  <= w_guard;
                r_s1_sticky <= w_sticky;
                r_s1_sign   <= in_sign;
                r_s1_cls    <= w_cls;
            end
        end
    end

    // Stage 2: round (carry may ripple into the regime) and negate
    always_comb begin
`ifdef POSIT16_PACK_RNE_EN
        w_inc = r_s1_guard && (r_s1_sticky || r_s1_body[0]);
`else
        w_inc = 1'b0;
`endif
        w_mag         = {1'b0, r_s1_body} + {15'b0, w_inc};
        w_res_posit   = r_s1_sign ? (~w_mag + 16'd1) : w_mag;
        w_res_inexact = r_s1_guard || r_s1_sticky;
        case (r_s1_cls)
            CLS_NAR: begin
                w_res_posit   = 16'h8000;
                w_res_inexact = 1'b0;
            end
            CLS_ZERO: begin
                w_res_posit   = 16'h0000;
                w_res_inexact = 1'b0;
            end
            default: ;
        endcase
    end

    // Stage 2 register: result holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_posit    <= '0;
            r_inexact  <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_posit   <= w_res_posit;
                r_inexact <= w_res_inexact;
            end
        end
    end

endmodule

// File: tb/tb_posit16_pack.sv
// Scoreboard bench for posit16_pack: a driver pushes model results into a
// queue on each input transfer; a negedge monitor pops and compares on each
// output transfer and checks handshake rules and stall stability.
module tb_posit16_pack;

    localparam int FW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic          in_zero;
    logic          in_nar;
    logic [15:0]   in_exp;
    logic [FW-1:0] in_frac;
    logic [15:0]   in_regbits;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_posit;
    logic          out_inexact;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int cyc   = 0;

    logic [16:0] q[$];
    logic [16:0] exp_word;
    logic        prev_stall;
    logic [15:0] prev_posit;
    logic        prev_inexact;

    posit16_pack #(.FRAC_W(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_zero    (in_zero),
        .in_nar     (in_nar),
        .in_exp     (in_exp),
        .in_frac    (in_frac),
        .in_regbits (in_regbits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, req);
        end
    endtask

    // regime bitstring as the upstream generator would produce it
    function automatic logic [15:0] regbits(input int k);
        longint r;
        int     len;
        if (k >= 14) return 16'h7FFF;
        if (k <= -14) return 16'h0001;
        if (k >= 0) begin
            r   = ((64'sd1 <<< (k + 1)) - 1) <<< 1;
            len = k + 2;
        end else begin
            r   = 1;
            len = 1 - k;
        end
        return 16'(r <<< (15 - len));
    endfunction

    // reference: concatenate regime and fraction as one integer, keep the
    // top 15 bits and round the remainder arithmetically
    function automatic logic [16:0] model(input logic s, input logic z, input logic n,
                                          input int k, input logic [FW-1:0] f);
        longint r, full, rem, half, body;
        int     len, sh;
        logic   inx;
        logic [15:0] p;
        if (n) return {1'b0, 16'h8000};
        if (z) return 17'h0;
        if (k >= 14) begin
            body = 32767;
            inx  = (k > 14) || (f != 0);
        end else if (k <= -14) begin
            body = 1;
            inx  = (k < -14) || (f != 0);
        end else begin
            if (k >= 0) begin
                r   = ((64'sd1 <<< (k + 1)) - 1) <<< 1;
                len = k + 2;
            end else begin
                r   = 1;
                len = 1 - k;
            end
            full = (r <<< FW) | longint'(f);
            sh   = len + FW - 15;
            body = full >>> sh;
            rem  = full & ((64'sd1 <<< sh) - 1);
            half = 64'sd1 <<< (sh - 1);
            inx  = (rem != 0);
`ifdef POSIT16_PACK_RNE_EN
            if (rem > half || (rem == half && body[0])) body = body + 1;
`endif
        end
        p = s ? 16'(-body) : 16'(body);
        return {inx, p};
    endfunction

    // out_ready pattern generator
    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        cyc++;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_posit", 32'(out_posit), 32'(prev_posit));
                chk("hold_inexact", 32'(out_inexact), 32'(prev_inexact));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(out_posit), 32'hDEAD_0000);
                end else begin
                    e = q.pop_front();
                    chk("posit", 32'(out_posit), 32'(e[15:0]));
                    chk("inexact", 32'(out_inexact), 32'(e[16]));
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_posit   = out_posit;
            prev_inexact = out_inexact;
            if (in_valid && in_ready) q.push_back(exp_word);
        end
    end

    // called just after a posedge; returns just after the accepting posedge
    task automatic send(input logic s, input logic z, input logic n,
                        input int k, input logic [FW-1:0] f);
        logic [15:0] rb;
        logic        acc;
        rb         = regbits(k);
        rb[15]     = 1'($urandom_range(0, 1));
        in_sign    = s;
        in_zero    = z;
        in_nar     = n;
        in_exp     = 16'(k);
        in_frac    = f;
        in_regbits = rb;
        exp_word   = model(s, z, n, k, f);
        in_valid   = 1'b1;
        acc        = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand();
        int   k;
        logic z, n;
        k = int'($urandom_range(0, 40)) - 20;
        z = ($urandom_range(0, 15) == 0);
        n = ($urandom_range(0, 15) == 0);
        send(1'($urandom_range(0, 1)), z, n, k, FW'($urandom));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
        in_exp = '0; in_frac = '0; in_regbits = '0; out_ready = 1'b1;
        exp_word = '0; prev_stall = 1'b0; prev_posit = '0; prev_inexact = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_posit", 32'(out_posit), 32'd0);
        chk("reset_out_inexact", 32'(out_inexact), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // directed vectors and boundaries
        mode = 0;
        send(0, 0, 0,   0, 23'h000000);
        send(0, 0, 0,   1, 23'h000000);
        send(0, 0, 0,  -1, 23'h000000);
        send(0, 0, 0,   0, 23'h400000);
        send(1, 0, 0,   0, 23'h400000);
        send(1, 0, 0,   0, 23'h000000);
        send(0, 0, 0,   0, 23'h000200);
        send(0, 0, 0,   0, 23'h000600);
        send(0, 0, 0,   0, 23'h000201);
        send(0, 0, 0,  20, 23'h000000);
        send(1, 0, 0, -20, 23'h000000);
        send(0, 0, 0,  13, 23'h7FFFFF);
        send(0, 0, 0,  14, 23'h000000);
        send(0, 0, 0, -14, 23'h000000);
        send(0, 0, 0, -13, 23'h7FFFFF);
        send(1, 0, 0, -13, 23'h400001);
        send(0, 0, 1,   3, 23'h000005);
        send(1, 1, 0,   2, 23'h000007);
        idle(4);

        // back-to-back stream under 1-0-0-1 backpressure
        mode = 1;
        for (int i = 0; i < 8; i++) send_rand();
        idle(12);

        // reset with two operands in flight
        mode = 3;
        send(0, 0, 0, 1, 23'h123456);
        send(1, 0, 0, -2, 23'h654321);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flush_out_posit", 32'(out_posit), 32'd0);
        chk("rst_flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        mode = 0;
        idle(6);

        // randomized traffic with random gaps and random backpressure
        mode = 2;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        in_valid = 1'b0;

        // drain
        mode = 0;
        for (int c = 0; c < 100 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
